// File: rtl/blowfish_dec_iter_pkg.sv
// Shared Blowfish definitions: pi-derived P constants, round count, FSM states and subkey helper.
package blowfish_pkg;

  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned KEY_WORDS  = 14;

  // P_ARRAY[0] is P1.
  localparam logic [31:0] P_ARRAY [18] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
    32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
    32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
    32'h9216d5d9, 32'h8979fb1b
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // par_idx = P_idx ^ k_(((idx-1) mod 14)+1); k1 sits in the top word of the key.
  function automatic logic [31:0] subkey(input logic [447:0] key, input logic [4:0] idx);
    logic [4:0] pos;
    logic [3:0] word;
    pos  = idx - 5'd1;
    word = 4'(pos % 5'(KEY_WORDS));
    return P_ARRAY[pos] ^ key[32*(13 - int'(word)) +: 32];
  endfunction

endpackage

// File: rtl/blowfish_dec_iter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the iterative Blowfish decryptor.
interface blowfish_dec_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ct;
  logic [448:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  pt;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt
  );
endinterface

// File: rtl/blowfish_dec_iter_feistel.sv
// Blowfish F-function ((S1[a] + S2[b]) ^ S3[c]) + S4[d]; S-box entries are generated
// arithmetically from the byte index instead of being stored.
module feistel (
  input  logic [31:0] x,
  output logic [31:0] f
);

  localparam logic [31:0] SboxMul [4] = '{32'h9e3779b1, 32'h85ebca6b, 32'hc2b2ae35, 32'h27d4eb2f};
  localparam logic [31:0] SboxXor [4] = '{32'h7f4a7c15, 32'h165667b1, 32'hd3a2646c, 32'hfd7046c5};

  logic [31:0] s [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i] = ({24'd0, x[31-8*i -: 8]} * SboxMul[i]) ^ SboxXor[i];
    end
    f = ((s[0] + s[1]) ^ s[2]) + s[3];
  end

endmodule

// File: rtl/blowfish_dec_iter.sv
// Iterative Blowfish decryptor: 16 Feistel rounds with reversed subkeys, one round per cycle
// (two per cycle when BLOWFISH_DEC_UNROLL2_EN is defined).
module blowfish_dec_iter
  import blowfish_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  blowfish_dec_iter_if.slave bus
);

`ifdef BLOWFISH_DEC_UNROLL2_EN
  localparam logic [3:0] RndStep = 4'd2;
`else
  localparam logic [3:0] RndStep = 4'd1;
`endif
  localparam logic [3:0] RndLast = 4'(NUM_ROUNDS - 32'(RndStep));

  state_e        state_q, state_d;
  logic [31:0]   xl_q, xr_q;
  logic [3:0]    rnd_q;
  logic [447:0]  key_q;
  logic          out_valid_q;
  logic [63:0]   pt_q;
  logic          last_rnd;

  logic [4:0]    idx_a;
  logic [31:0]   t_a, f_a, xl_a;
  logic [31:0]   xl_n, xr_n;

  logic          unused_key_msb;
  assign unused_key_msb = bus.key[448];

  assign last_rnd = (rnd_q == RndLast);

  // First round of the cycle uses par_(18-rnd).
  assign idx_a = 5'd18 - {1'b0, rnd_q};
  assign t_a   = xl_q ^ subkey(key_q, idx_a);

  feistel u_feistel_a (
    .x (t_a),
    .f (f_a)
  );

  assign xl_a = xr_q ^ f_a;

`ifdef BLOWFISH_DEC_UNROLL2_EN
  logic [4:0]  idx_b;
  logic [31:0] t_b, f_b;

  assign idx_b = 5'd17 - {1'b0, rnd_q};
  assign t_b   = xl_a ^ subkey(key_q, idx_b);

  feistel u_feistel_b (
    .x (t_b),
    .f (f_b)
  );

  assign xl_n = t_a ^ f_b;
  assign xr_n = t_b;
`else
  assign xl_n = xl_a;
  assign xr_n = t_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)  state_d = StRun;
      StRun:   if (last_rnd)      state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xl_q        <= '0;
      xr_q        <= '0;
      rnd_q       <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      pt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            xl_q  <= bus.ct[63:32];
            xr_q  <= bus.ct[31:0];
            rnd_q <= '0;
            key_q <= bus.key[447:0];
          end
        end
        StRun: begin
          xl_q <= xl_n;
          xr_q <= xr_n;
          if (last_rnd) begin
            // Final swap is undone here by pairing xr with par1 and xl with par2.
            out_valid_q <= 1'b1;
            pt_q        <= {xr_n ^ subkey(key_q, 5'd1), xl_n ^ subkey(key_q, 5'd2)};
          end else begin
            rnd_q <= rnd_q + RndStep;
          end
        end
        StDone: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pt        = pt_q;

endmodule

// File: tb/tb_blowfish_dec_iter.sv
// Scoreboard bench: plaintexts are encrypted by a reference Blowfish model, fed to the decryptor,
// and the recovered plaintext is compared by an independent monitor.
module tb_blowfish_dec_iter;

`ifdef BLOWFISH_DEC_UNROLL2_EN
  localparam int Lat = 9;
`else
  localparam int Lat = 17;
`endif
  localparam int Period   = Lat + 1;
  localparam int Scramble = Lat - 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blowfish_dec_iter_if bus ();

  blowfish_dec_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] pi_p [18] = '{
    32'h243f6a88, 32'h85a308d3, 32'h13198a2e, 32'h03707344,
    32'ha4093822, 32'h299f31d0, 32'h082efa98, 32'hec4e6c89,
    32'h452821e6, 32'h38d01377, 32'hbe5466cf, 32'h34e90c6c,
    32'hc0ac29b7, 32'hc97c50dd, 32'h3f84d5b5, 32'hb5470917,
    32'h9216d5d9, 32'h8979fb1b
  };
  logic [31:0] sb_mul [4] = '{32'h9e3779b1, 32'h85ebca6b, 32'hc2b2ae35, 32'h27d4eb2f};
  logic [31:0] sb_xor [4] = '{32'h7f4a7c15, 32'h165667b1, 32'hd3a2646c, 32'hfd7046c5};
  logic [31:0] sb [4][256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_issued = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];
  logic        hs_pending = 1'b0;
  logic [63:0] prev_pt = '0;
  logic [63:0] popped;
  int          acc_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ff(input logic [31:0] x);
    return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
  endfunction

  // Reference maincode: standard Blowfish encryption with key words cycled over P1..P18.
  function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [447:0] k);
    logic [31:0] pa [18];
    logic [31:0] l, r, tmp;
    for (int i = 0; i < 18; i++) pa[i] = pi_p[i] ^ k[32*(13 - (i % 14)) +: 32];
    l = p[63:32];
    r = p[31:0];
    for (int i = 0; i < 16; i++) begin
      l   = l ^ pa[i];
      r   = r ^ ff(l);
      tmp = l; l = r; r = tmp;
    end
    tmp = l; l = r; r = tmp;
    r = r ^ pa[16];
    l = l ^ pa[17];
    return {l, r};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [448:0] rnd_key();
    logic [479:0] w;
    for (int i = 0; i < 15; i++) w[32*i +: 32] = $urandom;
    return w[448:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_pending = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (bus.out_valid) begin
        chk("in_ready_low_while_out_valid", 64'(bus.in_ready), 64'd0);
        if (hs_pending) begin
          chk("pt_stable_under_backpressure", bus.pt, prev_pt);
        end else if (acc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL latency: out_valid with no accepted block (cycle %0d)", cyc);
        end else begin
          acc_pop = acc_q.pop_front();
          chk("latency_accept_to_out_valid", 64'(cyc - acc_pop), 64'(Lat));
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL pt: unexpected output %h (cycle %0d)", bus.pt, cyc);
          end else begin
            popped = exp_q.pop_front();
            chk("pt_round_trip", bus.pt, popped);
          end
          hs_pending = 1'b0;
        end else begin
          hs_pending = 1'b1;
        end
      end else begin
        hs_pending = 1'b0;
      end
      prev_pt = bus.pt;
    end
  end

  // Offers ct=maincode(p,k) and returns the cycle in which the accept was seen.
  task automatic issue(input logic [63:0] p, input logic [448:0] k, output int acc);
    int n;
    bus.ct       = encrypt(p, k[447:0]);
    bus.key      = k;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      $display("FAIL accept: in_ready never asserted (cycle %0d)", cyc);
      $fatal(1);
    end
    exp_q.push_back(p);
    n_issued++;
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d outputs missing, wanted 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2, n;
    logic [63:0]  p;
    logic [448:0] k;

    for (int j = 0; j < 4; j++)
      for (int v = 0; v < 256; v++) sb[j][v] = (32'(v) * sb_mul[j]) ^ sb_xor[j];

    bus.in_valid  = 1'b0;
    bus.ct        = '0;
    bus.key       = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_pt", bus.pt, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero round trip.
    issue(64'd0, 449'd0, a1);
    bus.in_valid = 1'b0;
    wait_drain();

    // Backpressure: hold out_ready low for 20 cycles after out_valid.
    bus.out_ready = 1'b0;
    issue(rnd64(), rnd_key(), a1);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Key/ct scrambled during RUN with in_valid held high.
    issue(rnd64(), rnd_key(), a1);
    repeat (Scramble) begin
      bus.ct  = rnd64();
      bus.key = rnd_key();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of RUN discards the block.
    issue(rnd64(), rnd_key(), a1);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midreset_pt", bus.pt, 64'd0);
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(rnd64(), rnd_key(), a1);
    bus.in_valid = 1'b0;
    wait_drain();

    // Back-to-back accepts with in_valid held high.
    issue(rnd64(), rnd_key(), a1);
    issue(rnd64(), rnd_key(), a2);
    bus.in_valid = 1'b0;
    chk("b2b_accept_spacing", 64'(a2 - a1), 64'(Period));
    wait_drain();

    // Random round trips, key bit 448 random.
    for (int i = 0; i < 1000; i++) begin
      p = rnd64();
      k = rnd_key();
      issue(p, k, a1);
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    chk("accept_count", 64'(n_acc), 64'(n_issued));
    chk("pending_accepts", 64'(acc_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blowfish_dec_iter.md
# blowfish_dec_iter

Iterative Blowfish decryptor and the receive-side counterpart of the combinational `maincode` encryptor. It accepts a 64-bit ciphertext and the 449-bit key over a valid/ready handshake. It runs the 16 Feistel rounds with the subkeys in reverse order, one round per clock, and returns the recovered plaintext over a second valid/ready handshake. It sits on the receive path, so any `ct` produced by `maincode` with the same key decrypts back to the original `pt`.

## Interface
- No parameters. Round count (16) and the P constants are fixed in the package.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: ciphertext/key offered.
- `in_ready` out 1: block can accept a new ciphertext.
- `ct` in 64: ciphertext; [63:32] is the left half, [31:0] is the right half.
- `key` in 449: same layout as the encryptor. k1=[447:416] … k14=[31:0]; bit 448 is ignored.
- `out_valid` out 1: plaintext available.
- `out_ready` in 1: consumer accepts the plaintext.
- `pt` out 64: recovered plaintext; [63:32] is the left half.

## Operation
- Subkeys: par_i = P_i ^ k_(((i-1) mod 14)+1) for i=1..18, with P_i equal to the standard Blowfish pi constants (P1=32'h243f6a88 … P18=32'h8979fb1b). There is no further key schedule; this matches the encryptor exactly.
- The key is captured into a 448-bit register on the accept cycle. Later changes on `key` do not affect a block in flight.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1: xl<=ct[63:32], xr<=ct[31:0], rnd<=0, go to RUN.
- RUN, one round per cycle:
  - t = xl ^ par_(18-rnd); xl <= xr ^ F(t); xr <= t; rnd <= rnd+1.
  - When rnd==15, go to DONE. Rounds use par18 down to par3.
- DONE:
  - `out_valid`=1 and pt = {xr ^ par1, xl ^ par2}, which undoes the final swap and applies par1/par2.
  - `pt` is held stable while `out_ready`=0.
  - When `out_ready`=1, go to IDLE.
- `in_ready` is 0 in RUN and DONE. There is no overlap: a new accept is possible in the cycle after the output handshake.
- F is the existing `feistel` function: 32-bit input, 32-bit combinational output, unchanged.
- All XORs are 32-bit. `rnd` is a 4-bit counter and never wraps inside a block.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `pt`=64'h0, xl=xr=0, rnd=0, key register=0.
- Reset asserted in any state returns the FSM to IDLE on the next edge. The block in flight is discarded and `out_valid` drops.
- Latency: accept at edge N gives `out_valid`=1 after edge N+17 (16 RUN cycles plus the DONE entry).
- Throughput: one block per 18 cycles when `out_ready` is held high.
- `out_valid` and `pt` are registered. `in_ready` is decoded directly from the state register.
- `in_valid` seen in RUN or DONE is ignored. The upstream side holds its data until `in_ready`.

## Configuration
- `BLOWFISH_DEC_UNROLL2_EN`:
  - Defined: two rounds per RUN cycle using two `feistel` instances. rnd steps by 2 and the exit condition is rnd==14. Latency becomes 9 cycles from accept to `out_valid`; throughput becomes one block per 10 cycles.
  - Undefined: one round per cycle as described above.
- The data result is identical in both configurations.

## Structure
- Package `blowfish_pkg` holds:
  - P1..P18 as a localparam array.
  - The NUM_ROUNDS=16 constant.
  - The FSM state enum (IDLE/RUN/DONE).
  - A function computing par_i from the key register and index.
- One sub-module: the existing `feistel` F-function, instantiated once (twice with UNROLL2). It is not duplicated or modified.
- The package is shared with future encrypt-side sequential blocks.

## Test plan
- Round trip: ct=`maincode`(pt=64'h0, key=0) fed in with key=0 and `out_ready`=1 → `pt`=64'h0000000000000000, `out_valid` exactly 17 cycles after accept (9 with UNROLL2).
- Round trip, random: 1000 random (pt, key) pairs encrypted by `maincode`, then decrypted → `pt` matches every time. Key bit 448 is toggled randomly with no effect on the result.
- Backpressure: `out_ready`=0 for 20 cycles after `out_valid` → `pt` and `out_valid` are stable and `in_ready`=0 throughout. Raising `out_ready` gives IDLE and `in_ready`=1 on the next cycle.
- Key/input isolation: change `key` and `ct` every cycle during RUN with `in_valid`=1 → the result equals decryption of the values present on the accept cycle, and no second accept occurs.
- Reset mid-operation: pull `rst_n` low at RUN round 7 → next edge gives `out_valid`=0, `in_ready`=1, `pt`=0. A following block decrypts correctly.
- Back-to-back: two blocks with `in_valid` held high and `out_ready`=1 → second accept is 18 cycles after the first and both outputs are correct.
